mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the fetch stage's instruction port and the memory stage's data port.
- Sits between the core's pipeline stages and the memory model.
- Accepts one request at a time, forwards it to memory, and routes read data back to the requester.
- Arbitration is round-robin or fixed data-priority, selected by parameter.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Request/response and memory-side signals of the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic                  i_ready;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_valid;

    logic [2:0]            d_cmd;
    logic                  d_cmd_ready;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_wmask;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_rdata_valid;

    logic                  mem_start;
    logic                  mem_ready;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdata_valid;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  i_start, i_addr, d_cmd, d_addr, d_wdata, d_wmask,
               mem_ready, mem_rdata, mem_rdata_valid,
        output i_ready, i_rdata, i_valid, d_cmd_ready, d_rdata, d_rdata_valid,
               mem_start, mem_write, mem_addr, mem_wdata, mem_wmask, busy
    );

    // Pipeline stages plus memory model side
    modport master (
        output i_start, i_addr, d_cmd, d_addr, d_wdata, d_wmask,
               mem_ready, mem_rdata, mem_rdata_valid,
        input  i_ready, i_rdata, i_valid, d_cmd_ready, d_rdata, d_rdata_valid,
               mem_start, mem_write, mem_addr, mem_wdata, mem_wmask, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported memory between instruction and data ports.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit FAIR       = 1'b1
) (
    input wire                clk,
    input wire                rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic       c_own_inst = 1'b0;
    localparam logic       c_own_data = 1'b1;
    localparam logic [2:0] c_cmd_rd   = 3'b001;
    localparam logic [2:0] c_cmd_wr   = 3'b010;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_wmask;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_i_valid;
    logic                  r_d_valid;

    logic w_i_req;
    logic w_d_req;
    logic w_d_write;
    logic w_tie_data;
    logic w_idle;
    logic w_i_ready;
    logic w_d_ready;
    logic w_i_acc;
    logic w_d_acc;
    logic w_rsp;

    assign w_i_req   = bus.i_start;
    assign w_d_req   = (bus.d_cmd == c_cmd_rd) || (bus.d_cmd == c_cmd_wr);
    assign w_d_write = (bus.d_cmd == c_cmd_wr);
    assign w_idle    = (r_state == IDLE);

    // Tie-break when both ports request in the same IDLE cycle
    generate
        if (FAIR) begin : g_round_robin
            assign w_tie_data = (r_last_grant == c_own_inst);
        end else begin : g_data_priority
            assign w_tie_data = 1'b1;
        end
    endgenerate

    assign w_i_ready = w_idle && (!w_d_req || (w_i_req && !w_tie_data));
    assign w_d_ready = w_idle && (!w_i_req || (w_d_req && w_tie_data));
    assign w_i_acc   = w_i_req && w_i_ready;
    assign w_d_acc   = w_d_req && w_d_ready;
    assign w_rsp     = (r_state == WAIT_RD) && bus.mem_rdata_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.mem_start = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        case (r_state)
            IDLE: begin
                if (w_i_acc || w_d_acc) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_start = 1'b1;
                bus.mem_write = r_write;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = r_wdata;
                bus.mem_wmask = r_wmask;
                if (bus.mem_ready) begin
                    w_state_nxt = r_write ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.mem_rdata_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture on accept; write data and mask stay zero for reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner      <= c_own_inst;
            r_last_grant <= c_own_inst;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            if (w_d_acc) begin
                r_owner      <= c_own_data;
                r_last_grant <= c_own_data;
                r_write      <= w_d_write;
                r_addr       <= bus.d_addr;
                r_wdata      <= w_d_write ? bus.d_wdata : '0;
                r_wmask      <= w_d_write ? bus.d_wmask : '0;
            end else if (w_i_acc) begin
                r_owner      <= c_own_inst;
                r_last_grant <= c_own_inst;
                r_write      <= 1'b0;
                r_addr       <= bus.i_addr;
                r_wdata      <= '0;
                r_wmask      <= '0;
            end
            if (w_rsp) begin
                if (r_owner == c_own_data) begin
                    r_d_rdata <= bus.mem_rdata;
                    r_d_valid <= 1'b1;
                end else begin
                    r_i_rdata <= bus.mem_rdata;
                    r_i_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.i_ready       = w_i_ready;
    assign bus.d_cmd_ready   = w_d_ready;
    assign bus.i_rdata       = r_i_rdata;
    assign bus.i_valid       = r_i_valid;
    assign bus.d_rdata       = r_d_rdata;
    assign bus.d_rdata_valid = r_d_valid;
    assign bus.busy          = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and randomized self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif  ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif0 ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif.slave));
    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FAIR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0.slave));

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [31:0] m);
        return (o & ~m) | (w & m);
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bif.i_start = 1'b0; bif.i_addr = '0; bif.d_cmd = 3'b000; bif.d_addr = '0;
        bif.d_wdata = '0; bif.d_wmask = '0; bif.mem_ready = 1'b0; bif.mem_rdata = '0;
        bif.mem_rdata_valid = 1'b0;
        bif0.i_start = 1'b0; bif0.i_addr = '0; bif0.d_cmd = 3'b000; bif0.d_addr = '0;
        bif0.d_wdata = '0; bif0.d_wmask = '0; bif0.mem_ready = 1'b0; bif0.mem_rdata = '0;
        bif0.mem_rdata_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) adv();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) adv();
        @(negedge clk);
        n_checks++; if (bif.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bif.busy); else n_pass++;
        n_checks++; if ({bif.mem_start, bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.mem_wmask} !== '0)
            $display("FAIL reset_mem_bus got start=%b addr=%h want all 0", bif.mem_start, bif.mem_addr); else n_pass++;
        n_checks++; if ({bif.i_valid, bif.d_rdata_valid, bif.i_rdata, bif.d_rdata} !== '0)
            $display("FAIL reset_responses got iv=%b dv=%b ir=%h dr=%h want 0", bif.i_valid, bif.d_rdata_valid, bif.i_rdata, bif.d_rdata); else n_pass++;
        n_checks++; if ({bif.i_ready, bif.d_cmd_ready} !== 2'b11)
            $display("FAIL reset_ready got=%b%b want=11", bif.i_ready, bif.d_cmd_ready); else n_pass++;
        n_checks++; if ({bif0.busy, bif0.mem_start, bif0.i_ready, bif0.d_cmd_ready} !== 4'b0011)
            $display("FAIL reset_fixed got=%b%b%b%b want=0011", bif0.busy, bif0.mem_start, bif0.i_ready, bif0.d_cmd_ready); else n_pass++;
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_inst_read();
        bif.i_start = 1'b1; bif.i_addr = 32'h100; bif.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bif.i_ready !== 1'b1) $display("FAIL ird_accept got i_ready=%b want=1", bif.i_ready); else n_pass++;
        adv();
        bif.i_start = 1'b0; bif.i_addr = '0;
        @(negedge clk);
        n_checks++; if ({bif.mem_start, bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.mem_wmask, bif.busy} !== {1'b1, 1'b0, 32'h100, 64'h0, 1'b1})
            $display("FAIL ird_issue got start=%b wr=%b addr=%h wd=%h busy=%b want 1 0 100 0 1",
                     bif.mem_start, bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.busy); else n_pass++;
        n_checks++; if (bif.i_ready !== 1'b0) $display("FAIL ird_busy_ready got=%b want=0", bif.i_ready); else n_pass++;
        adv();
        bif.mem_ready = 1'b0; bif.mem_rdata = 32'h13; bif.mem_rdata_valid = 1'b1;
        @(negedge clk);
        n_checks++; if ({bif.mem_start, bif.i_valid} !== 2'b00) $display("FAIL ird_wait got start=%b iv=%b want 0 0", bif.mem_start, bif.i_valid); else n_pass++;
        adv();
        bif.mem_rdata_valid = 1'b0; bif.mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({bif.i_valid, bif.i_rdata, bif.d_rdata_valid, bif.busy} !== {1'b1, 32'h13, 1'b0, 1'b0})
            $display("FAIL ird_resp got iv=%b ir=%h dv=%b busy=%b want 1 13 0 0", bif.i_valid, bif.i_rdata, bif.d_rdata_valid, bif.busy); else n_pass++;
        adv();
        @(negedge clk);
        n_checks++; if ({bif.i_valid, bif.i_rdata} !== {1'b0, 32'h13}) $display("FAIL ird_hold got iv=%b ir=%h want 0 13", bif.i_valid, bif.i_rdata); else n_pass++;
        adv();
    endtask

    task automatic test_round_robin();
        do_reset();
        bif.i_start = 1'b1; bif.i_addr = 32'h10; bif.d_cmd = 3'b001; bif.d_addr = 32'h20; bif.mem_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            bit exp_data = (n % 2 == 0);
            @(negedge clk);
            n_checks++; if ({bif.d_cmd_ready, bif.i_ready} !== {exp_data, !exp_data})
                $display("FAIL rr_grant%0d got d_rdy=%b i_rdy=%b want %b %b", n, bif.d_cmd_ready, bif.i_ready, exp_data, !exp_data); else n_pass++;
            if (n > 0) begin
                n_checks++;
                if (exp_data ? ({bif.i_valid, bif.i_rdata} !== {1'b1, 32'hA0 + 32'(n - 1)})
                             : ({bif.d_rdata_valid, bif.d_rdata} !== {1'b1, 32'hA0 + 32'(n - 1)}))
                    $display("FAIL rr_resp%0d got iv=%b ir=%h dv=%b dr=%h want prev pulse data %h", n,
                             bif.i_valid, bif.i_rdata, bif.d_rdata_valid, bif.d_rdata, 32'hA0 + 32'(n - 1));
                else n_pass++;
            end
            adv();
            @(negedge clk);
            n_checks++; if ({bif.mem_start, bif.mem_addr} !== {1'b1, exp_data ? 32'h20 : 32'h10})
                $display("FAIL rr_addr%0d got start=%b addr=%h", n, bif.mem_start, bif.mem_addr); else n_pass++;
            adv();
            bif.mem_rdata_valid = 1'b1; bif.mem_rdata = 32'hA0 + 32'(n);
            adv();
            bif.mem_rdata_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if ({bif.d_rdata_valid, bif.d_rdata, bif.i_ready} !== {1'b1, 32'hA2, 1'b1})
            $display("FAIL rr_final got dv=%b dr=%h i_rdy=%b want 1 a2 1", bif.d_rdata_valid, bif.d_rdata, bif.i_ready); else n_pass++;
        drive_idle();
        adv();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        bif0.i_start = 1'b1; bif0.i_addr = 32'h30; bif0.d_cmd = 3'b010; bif0.d_addr = 32'h34;
        bif0.d_wdata = 32'h1234; bif0.d_wmask = 32'hFF; bif0.mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (bif0.i_ready !== 1'b0) $display("FAIL fix_i_ready%0d got=%b want=0", c, bif0.i_ready); else n_pass++;
            n_checks++;
            if (c % 2 == 0) begin
                if (bif0.d_cmd_ready !== 1'b1) $display("FAIL fix_d_ready%0d got=%b want=1", c, bif0.d_cmd_ready); else n_pass++;
            end else begin
                if ({bif0.mem_start, bif0.mem_write, bif0.mem_addr} !== {1'b1, 1'b1, 32'h34})
                    $display("FAIL fix_issue%0d got start=%b wr=%b addr=%h want 1 1 34", c, bif0.mem_start, bif0.mem_write, bif0.mem_addr);
                else n_pass++;
            end
            adv();
        end
        drive_idle();
        adv();
    endtask

    task automatic test_write_stall();
        bif.d_cmd = 3'b010; bif.d_addr = 32'h200; bif.d_wdata = 32'hDEADBEEF; bif.d_wmask = 32'hFFFFFFFF;
        bif.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bif.d_cmd_ready !== 1'b1) $display("FAIL wr_accept got=%b want=1", bif.d_cmd_ready); else n_pass++;
        adv();
        bif.d_cmd = 3'b000; bif.d_addr = 32'h999; bif.d_wdata = '0; bif.d_wmask = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({bif.mem_start, bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.mem_wmask} !==
                            {1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFF})
                $display("FAIL wr_stall%0d got start=%b wr=%b addr=%h wd=%h wm=%h", i,
                         bif.mem_start, bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.mem_wmask); else n_pass++;
            n_checks++; if ({bif.i_ready, bif.d_cmd_ready} !== 2'b00)
                $display("FAIL wr_stall_ready%0d got=%b%b want=00", i, bif.i_ready, bif.d_cmd_ready); else n_pass++;
            adv();
        end
        bif.mem_ready = 1'b1;
        adv();
        bif.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({bif.busy, bif.mem_start, bif.i_valid, bif.d_rdata_valid, bif.d_cmd_ready} !== 5'b00001)
                $display("FAIL wr_done%0d got busy=%b start=%b iv=%b dv=%b d_rdy=%b", i,
                         bif.busy, bif.mem_start, bif.i_valid, bif.d_rdata_valid, bif.d_cmd_ready); else n_pass++;
            adv();
        end
    endtask

    task automatic test_no_request();
        logic [2:0] cmds [4] = '{3'b000, 3'b111, 3'b011, 3'b100};
        for (int k = 0; k < 4; k++) begin
            bif.i_start = 1'b0; bif.d_cmd = cmds[k]; bif.d_addr = 32'h44;
            bif.mem_ready = 1'b1; bif.mem_rdata_valid = 1'b1; bif.mem_rdata = 32'hFFFF0000;
            adv();
            @(negedge clk);
            n_checks++; if ({bif.busy, bif.mem_start, bif.i_valid, bif.d_rdata_valid, bif.i_ready, bif.d_cmd_ready} !== 6'b000011)
                $display("FAIL noreq_cmd%0d got busy=%b start=%b iv=%b dv=%b rdy=%b%b want 0 0 0 0 11", cmds[k],
                         bif.busy, bif.mem_start, bif.i_valid, bif.d_rdata_valid, bif.i_ready, bif.d_cmd_ready); else n_pass++;
            adv();
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        bif.d_cmd = 3'b001; bif.d_addr = 32'h40; bif.mem_ready = 1'b1;
        adv();
        bif.d_cmd = 3'b000;
        adv();
        bif.mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({bif.busy, bif.mem_start} !== 2'b10) $display("FAIL rmid_wait got busy=%b start=%b want 1 0", bif.busy, bif.mem_start); else n_pass++;
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1; bif.mem_rdata_valid = 1'b1; bif.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        n_checks++; if (bif.busy !== 1'b0) $display("FAIL rmid_idle got busy=%b want 0", bif.busy); else n_pass++;
        adv();
        bif.mem_rdata_valid = 1'b0; bif.mem_rdata = '0;
        @(negedge clk);
        n_checks++; if ({bif.i_valid, bif.d_rdata_valid, bif.busy, bif.d_rdata} !== {3'b000, 32'h0})
            $display("FAIL rmid_stray got iv=%b dv=%b busy=%b dr=%h want 0 0 0 0", bif.i_valid, bif.d_rdata_valid, bif.busy, bif.d_rdata); else n_pass++;
        adv();
        bif.i_start = 1'b1; bif.i_addr = 32'h80; bif.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bif.i_ready !== 1'b1) $display("FAIL rmid_new_accept got=%b want=1", bif.i_ready); else n_pass++;
        adv();
        bif.i_start = 1'b0;
        @(negedge clk);
        n_checks++; if ({bif.mem_start, bif.mem_addr} !== {1'b1, 32'h80}) $display("FAIL rmid_new_issue got start=%b addr=%h", bif.mem_start, bif.mem_addr); else n_pass++;
        adv();
        bif.mem_ready = 1'b0; bif.mem_rdata_valid = 1'b1; bif.mem_rdata = 32'h55;
        adv();
        bif.mem_rdata_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({bif.i_valid, bif.i_rdata} !== {1'b1, 32'h55}) $display("FAIL rmid_new_resp got iv=%b ir=%h want 1 55", bif.i_valid, bif.i_rdata); else n_pass++;
        adv();
        drive_idle();
    endtask

    task automatic test_random(input int n_cycles);
        bit          m_busy = 0, m_issued = 0, m_last = 0, m_owner = 0, m_write = 0;
        logic [31:0] m_addr = '0, m_wdata = '0, m_wmask = '0;
        bit          exp_pi = 0, exp_pd = 0;
        logic [31:0] exp_ir = '0, exp_dr = '0;
        bit          rd_pend = 0;
        int          rd_cnt = 0;
        logic [31:0] rd_addr = '0;
        do_reset();
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            bit d_req, i_req, win_d, win_i, pi, pd;
            bif.i_start = 1'($urandom_range(0, 1));
            bif.i_addr  = 32'($urandom_range(0, 15)) << 2;
            case ($urandom_range(0, 3))
                0: bif.d_cmd = 3'b001;
                1: bif.d_cmd = 3'b010;
                2: bif.d_cmd = 3'($urandom);
                default: bif.d_cmd = 3'b000;
            endcase
            bif.d_addr  = 32'($urandom_range(0, 15)) << 2;
            bif.d_wdata = $urandom;
            bif.d_wmask = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
            bif.mem_ready = ($urandom_range(0, 2) != 0);
            if (rd_pend && rd_cnt == 0) begin
                bif.mem_rdata_valid = 1'b1;
                bif.mem_rdata = env_mem.exists(rd_addr) ? env_mem[rd_addr] : init_word(rd_addr);
                rd_pend = 0;
            end else begin
                if (rd_pend) rd_cnt--;
                bif.mem_rdata_valid = !rd_pend && ($urandom_range(0, 7) == 0);
                bif.mem_rdata = $urandom;
            end
            @(negedge clk);
            n_checks++; if ({bif.i_valid, bif.d_rdata_valid} !== {exp_pi, exp_pd})
                $display("FAIL rnd_pulse c%0d got iv=%b dv=%b want %b %b", cyc, bif.i_valid, bif.d_rdata_valid, exp_pi, exp_pd); else n_pass++;
            n_checks++; if ({bif.i_rdata, bif.d_rdata} !== {exp_ir, exp_dr})
                $display("FAIL rnd_rdata c%0d got ir=%h dr=%h want %h %h", cyc, bif.i_rdata, bif.d_rdata, exp_ir, exp_dr); else n_pass++;
            d_req = (bif.d_cmd == 3'b001) || (bif.d_cmd == 3'b010);
            i_req = bif.i_start;
            win_d = d_req && (!i_req || (m_last == 1'b0));
            win_i = i_req && !win_d;
            pi = !m_busy && (!d_req || win_i);
            pd = !m_busy && (!i_req || win_d);
            n_checks++; if ({bif.i_ready, bif.d_cmd_ready, bif.busy, bif.mem_start} !== {pi, pd, m_busy, m_busy && !m_issued})
                $display("FAIL rnd_ctrl c%0d got rdy=%b%b busy=%b start=%b want %b%b %b %b", cyc, bif.i_ready, bif.d_cmd_ready,
                         bif.busy, bif.mem_start, pi, pd, m_busy, m_busy && !m_issued); else n_pass++;
            if (m_busy && !m_issued) begin
                n_checks++; if ({bif.mem_write, bif.mem_addr, bif.mem_wdata, bif.mem_wmask} !== {m_write, m_addr, m_wdata, m_wmask})
                    $display("FAIL rnd_membus c%0d got wr=%b a=%h wd=%h wm=%h want %b %h %h %h", cyc, bif.mem_write, bif.mem_addr,
                             bif.mem_wdata, bif.mem_wmask, m_write, m_addr, m_wdata, m_wmask); else n_pass++;
            end
            // Memory model reacts to whatever the arbiter actually presents
            if (bif.mem_start && bif.mem_ready) begin
                if (bif.mem_write) begin
                    env_mem[bif.mem_addr] = merge(env_mem.exists(bif.mem_addr) ? env_mem[bif.mem_addr] : init_word(bif.mem_addr),
                                                  bif.mem_wdata, bif.mem_wmask);
                end else begin
                    rd_pend = 1; rd_cnt = $urandom_range(0, 2); rd_addr = bif.mem_addr;
                end
            end
            exp_pi = 0; exp_pd = 0;
            if (!m_busy) begin
                if (win_d || win_i) begin
                    m_owner  = win_d;
                    m_write  = win_d && (bif.d_cmd == 3'b010);
                    m_addr   = win_d ? bif.d_addr : bif.i_addr;
                    m_wdata  = m_write ? bif.d_wdata : '0;
                    m_wmask  = m_write ? bif.d_wmask : '0;
                    m_busy   = 1; m_issued = 0; m_last = m_owner;
                    if (m_write)
                        ref_mem[m_addr] = merge(ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_word(m_addr), m_wdata, m_wmask);
                end
            end else if (!m_issued) begin
                if (bif.mem_ready) begin
                    if (m_write) m_busy = 0;
                    else m_issued = 1;
                end
            end else if (bif.mem_rdata_valid) begin
                logic [31:0] d;
                d = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_word(m_addr);
                m_busy = 0; m_issued = 0;
                if (m_owner) begin exp_pd = 1; exp_dr = d; end
                else         begin exp_pi = 1; exp_ir = d; end
            end
            adv();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_inst_read();
        test_round_robin();
        test_fixed_priority();
        test_write_stall();
        test_no_request();
        test_reset_mid_read();
        test_random(600);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
